dequantize_q8_24_stream: RTL and testbench

Streaming dequantizer: the inverse of the output quantizer. It converts 8-bit quantized activations back to signed Q8.24 fixed-point real values, computed as (q − ZERO_POINT) × SCALE. It sits between the quantized feature-map buffer and any stage that needs real-valued data, such as softmax/argmax, debug readback, or the next layer's fixed-point accumulator input. It uses a 3-stage valid/ready pipeline with frame-boundary tagging.

---
 rtl/dequant_pkg.sv | 16 +
 rtl/dequant_round_sat.sv | 34 +++
 rtl/dequantize_q8_24_stream.sv | 75 +++++++
 tb/tb_dequantize_q8_24_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dequant_pkg.sv
// rtl/dequant_pkg.sv - widths, default scale/zero point and clamp bounds shared with the quantizer
package dequant_pkg;
    localparam int Q_W        = 8;
    localparam int DIFF_W     = 9;
    localparam int PROD_W     = 42;
    localparam int OUT_W      = 32;
    localparam int OUT_FRAC   = 24;
    localparam int SCALE_FRAC = 32;
    localparam int DROP_BITS  = SCALE_FRAC - OUT_FRAC;

    localparam logic [31:0]      DEFAULT_SCALE_Q0_32 = 32'd512730592;
    localparam logic [Q_W-1:0]   DEFAULT_ZERO_POINT  = 8'd0;

    localparam logic [OUT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 32'h8000_0000;
endpackage

// File: rtl/dequant_round_sat.sv
// rtl/dequant_round_sat.sv - Q9.32 product to Q8.24 with clamp; DEQUANT_ROUND_EN selects half-up rounding over floor
module dequant_round_sat
    import dequant_pkg::*;
(
    input  logic signed [PROD_W-1:0] prod,
    output logic [OUT_W-1:0]         data,
    output logic                     sat
);
    localparam int SHIFT_W = PROD_W + 1 - DROP_BITS;

`ifdef DEQUANT_ROUND_EN
    localparam logic signed [PROD_W:0] ROUND_HALF =
        {{(PROD_W + 1 - DROP_BITS){1'b0}}, 1'b1, {(DROP_BITS - 1){1'b0}}};
`endif

    logic signed [PROD_W:0]   adj;
    logic [SHIFT_W-1:0]       shifted;
    logic [SHIFT_W-OUT_W:0]   upper;

    always_comb begin
        adj = {prod[PROD_W-1], prod};
`ifdef DEQUANT_ROUND_EN
        adj = adj + ROUND_HALF;
`endif
        shifted = SHIFT_W'(adj >>> DROP_BITS);
        // fits in OUT_W signed bits only when the sign bit and everything above it agree
        upper = shifted[SHIFT_W-1:OUT_W-1];
        sat   = !((&upper) | ~(|upper));
        data  = shifted[OUT_W-1:0];
        if (sat) begin
            data = shifted[SHIFT_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/dequantize_q8_24_stream.sv
// rtl/dequantize_q8_24_stream.sv - 3-stage valid/ready dequantizer q8 -> Q8.24 with frame tagging; DEQUANT_ROUND_EN enables rounding
module dequantize_q8_24_stream
    import dequant_pkg::*;
#(
    parameter logic [31:0]    SCALE_Q0_32 = DEFAULT_SCALE_Q0_32,
    parameter logic [Q_W-1:0] ZERO_POINT  = DEFAULT_ZERO_POINT,
    parameter int             FRAME_LEN   = 3025,
    parameter int             CNT_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_sat
);
    localparam logic signed [PROD_W-1:0] SCALE_EXT = {{(PROD_W - 32){1'b0}}, SCALE_Q0_32};

    logic                      en;
    logic                      tag_last;
    logic [CNT_W-1:0]          cnt;
    logic                      s1_valid, s1_last;
    logic signed [DIFF_W-1:0]  s1_diff;
    logic signed [PROD_W-1:0]  diff_ext;
    logic                      s2_valid, s2_last;
    logic signed [PROD_W-1:0]  s2_prod;
    logic [OUT_W-1:0]          s3_data;
    logic                      s3_sat;

    // the whole pipeline moves as one; a stalled output freezes every stage
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign tag_last = (cnt == CNT_W'(FRAME_LEN - 1));
    assign diff_ext = {{(PROD_W - DIFF_W){s1_diff[DIFF_W-1]}}, s1_diff};

    dequant_round_sat u_round_sat (
        .prod (s2_prod),
        .data (s3_data),
        .sat  (s3_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_diff   <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_last   <= in_valid & tag_last;
            s1_diff   <= $signed({1'b0, in_q}) - $signed({1'b0, ZERO_POINT});
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_prod   <= diff_ext * SCALE_EXT;
            out_valid <= s2_valid;
            out_data  <= s3_data;
            out_last  <= s2_last;
            out_sat   <= s3_sat;
            if (in_valid) begin
                cnt <= tag_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dequantize_q8_24_stream.sv
// tb/tb_dequantize_q8_24_stream.sv - self-checking bench: five parameterisations share one input stream
module tb_dequantize_q8_24_stream;
    localparam logic [31:0] SC_A = 32'h8000_0000;
    localparam logic [7:0]  ZP_A = 8'd0;
    localparam logic [31:0] SC_B = 32'h8000_0000;
    localparam logic [7:0]  ZP_B = 8'd20;
    localparam logic [31:0] SC_C = 32'd512730592;
    localparam logic [7:0]  ZP_C = 8'd0;
    localparam logic [31:0] SC_D = 32'hFFFF_FFFF;
    localparam logic [7:0]  ZP_D = 8'd0;
    localparam logic [31:0] SC_E = 32'hFFFF_FFFF;
    localparam logic [7:0]  ZP_E = 8'd255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_q = 8'd0;

    logic        rdy_a, vld_a, last_a, sat_a;
    logic        rdy_b, vld_b, last_b, sat_b;
    logic        rdy_c, vld_c, last_c, sat_c;
    logic        rdy_d, vld_d, last_d, sat_d;
    logic        rdy_e, vld_e, last_e, sat_e;
    logic [31:0] data_a, data_b, data_c, data_d, data_e;

    int n_tests = 0;
    int n_fail  = 0;

    dequantize_q8_24_stream #(.SCALE_Q0_32(SC_A), .ZERO_POINT(ZP_A), .FRAME_LEN(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_q(in_q),
        .out_valid(vld_a), .out_ready(out_ready), .out_data(data_a), .out_last(last_a), .out_sat(sat_a));
    dequantize_q8_24_stream #(.SCALE_Q0_32(SC_B), .ZERO_POINT(ZP_B), .FRAME_LEN(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_q(in_q),
        .out_valid(vld_b), .out_ready(out_ready), .out_data(data_b), .out_last(last_b), .out_sat(sat_b));
    dequantize_q8_24_stream #(.SCALE_Q0_32(SC_C), .ZERO_POINT(ZP_C), .FRAME_LEN(3025), .CNT_W(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_q(in_q),
        .out_valid(vld_c), .out_ready(out_ready), .out_data(data_c), .out_last(last_c), .out_sat(sat_c));
    dequantize_q8_24_stream #(.SCALE_Q0_32(SC_D), .ZERO_POINT(ZP_D), .FRAME_LEN(1), .CNT_W(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d), .in_q(in_q),
        .out_valid(vld_d), .out_ready(out_ready), .out_data(data_d), .out_last(last_d), .out_sat(sat_d));
    dequantize_q8_24_stream #(.SCALE_Q0_32(SC_E), .ZERO_POINT(ZP_E), .FRAME_LEN(3025), .CNT_W(12)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_e), .in_q(in_q),
        .out_valid(vld_e), .out_ready(out_ready), .out_data(data_e), .out_last(last_e), .out_sat(sat_e));

    // Reference: real value (q - zp) * scale / 2^32 expressed in units of 2^-24, floor or half-up, then clamped.
    // Returns {sat, data}.
    function automatic logic [32:0] ref_deq(input logic [7:0] q, input logic [7:0] zp, input logic [31:0] scale);
        longint d, p, r;
        d = longint'(q) - longint'(zp);
        p = d * longint'(scale);
`ifdef DEQUANT_ROUND_EN
        p = p + 128;
`endif
        r = p >>> 8;
        if (r > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, r[31:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (rdy_a !== 1'b1)      begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy_a); end
        n_tests++; if (vld_a !== 1'b0)      begin n_fail++; $display("FAIL reset_out_valid got %b want 0", vld_a); end
        n_tests++; if (data_a !== 32'h0)    begin n_fail++; $display("FAIL reset_out_data got %h want 0", data_a); end
        n_tests++; if (last_a !== 1'b0)     begin n_fail++; $display("FAIL reset_out_last got %b want 0", last_a); end
        n_tests++; if (sat_a !== 1'b0)      begin n_fail++; $display("FAIL reset_out_sat got %b want 0", sat_a); end
        n_tests++; if (vld_d !== 1'b0)      begin n_fail++; $display("FAIL reset_out_valid_d got %b want 0", vld_d); end
    endtask

    task automatic test_known_values();
        logic [7:0]  qs [5];
        logic [32:0] e;
        qs = '{8'd10, 8'd0, 8'd255, 8'd200, 8'd1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_q = qs[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 1; k < 3; k++) begin
                n_tests++;
                if (vld_a !== 1'b0) begin n_fail++; $display("FAIL latency_early q=%0d cycle=%0d out_valid got %b want 0", qs[i], k, vld_a); end
                @(negedge clk);
            end
            n_tests++;
            if (vld_a !== 1'b1) begin n_fail++; $display("FAIL latency_n3 q=%0d out_valid got %b want 1", qs[i], vld_a); end
            e = ref_deq(qs[i], ZP_A, SC_A);
            n_tests++; if ({sat_a, data_a} !== e) begin n_fail++; $display("FAIL value_a q=%0d got sat=%b data=%h want sat=%b data=%h", qs[i], sat_a, data_a, e[32], e[31:0]); end
            e = ref_deq(qs[i], ZP_B, SC_B);
            n_tests++; if ({sat_b, data_b} !== e) begin n_fail++; $display("FAIL value_b q=%0d got sat=%b data=%h want sat=%b data=%h", qs[i], sat_b, data_b, e[32], e[31:0]); end
            e = ref_deq(qs[i], ZP_C, SC_C);
            n_tests++; if ({sat_c, data_c} !== e) begin n_fail++; $display("FAIL value_c q=%0d got sat=%b data=%h want sat=%b data=%h", qs[i], sat_c, data_c, e[32], e[31:0]); end
            e = ref_deq(qs[i], ZP_D, SC_D);
            n_tests++; if ({sat_d, data_d} !== e) begin n_fail++; $display("FAIL value_d q=%0d got sat=%b data=%h want sat=%b data=%h", qs[i], sat_d, data_d, e[32], e[31:0]); end
            e = ref_deq(qs[i], ZP_E, SC_E);
            n_tests++; if ({sat_e, data_e} !== e) begin n_fail++; $display("FAIL value_e q=%0d got sat=%b data=%h want sat=%b data=%h", qs[i], sat_e, data_e, e[32], e[31:0]); end
            n_tests++; if (last_a !== (i % 4 == 3)) begin n_fail++; $display("FAIL last_a idx=%0d got %b want %b", i, last_a, (i % 4 == 3)); end
            n_tests++; if (last_c !== 1'b0) begin n_fail++; $display("FAIL last_c idx=%0d got %b want 0", i, last_c); end
            n_tests++; if (last_d !== 1'b1) begin n_fail++; $display("FAIL last_d_len1 idx=%0d got %b want 1", i, last_d); end
            if (qs[i] == 8'd10) begin
                n_tests++; if ({sat_a, data_a} !== {1'b0, 32'h0500_0000}) begin n_fail++; $display("FAIL half_scale_10 got sat=%b data=%h want sat=0 data=05000000", sat_a, data_a); end
            end
            if (qs[i] == 8'd0) begin
                n_tests++; if (data_b !== 32'hF600_0000) begin n_fail++; $display("FAIL zero_point_20 got %h want f6000000", data_b); end
                n_tests++; if ({sat_e, data_e} !== {1'b1, 32'h8000_0000}) begin n_fail++; $display("FAIL clamp_neg got sat=%b data=%h want sat=1 data=80000000", sat_e, data_e); end
            end
            if (qs[i] == 8'd200) begin
                n_tests++; if ({sat_d, data_d} !== {1'b1, 32'h7FFF_FFFF}) begin n_fail++; $display("FAIL clamp_pos got sat=%b data=%h want sat=1 data=7fffffff", sat_d, data_d); end
            end
        end
    endtask

    task automatic test_frame_stream();
        logic [7:0]  q_sent [$];
        logic [32:0] e;
        logic [31:0] hd;
        logic        hl, hs, held, acc;
        int sent, got, cyc;
        do_reset();
        sent = 0; got = 0; cyc = 0; held = 1'b0; acc = 1'b0;
        hd = '0; hl = 1'b0; hs = 1'b0;
        while (got < 10 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                n_tests++;
                if (vld_a !== 1'b1 || data_a !== hd || last_a !== hl || sat_a !== hs) begin
                    n_fail++;
                    $display("FAIL stall_stable got v=%b d=%h l=%b s=%b want v=1 d=%h l=%b s=%b", vld_a, data_a, last_a, sat_a, hd, hl, hs);
                end
            end
            if (acc) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid && sent < 10 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_q = 8'($urandom_range(0, 255));
            end
            #1;
            n_tests++;
            if (rdy_a !== (~vld_a | out_ready)) begin n_fail++; $display("FAIL in_ready_rule got %b want %b", rdy_a, (~vld_a | out_ready)); end
            if (vld_a && out_ready) begin
                if (q_sent.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_beat got data=%h want no beat", data_a);
                end else begin
                    e = ref_deq(q_sent[0], ZP_A, SC_A);
                    n_tests++; if ({sat_a, data_a} !== e) begin n_fail++; $display("FAIL stream_a beat=%0d got %h want %h", got, data_a, e[31:0]); end
                    e = ref_deq(q_sent[0], ZP_C, SC_C);
                    n_tests++; if ({sat_c, data_c} !== e) begin n_fail++; $display("FAIL stream_c beat=%0d got %h want %h", got, data_c, e[31:0]); end
                    n_tests++; if (last_a !== (got % 4 == 3)) begin n_fail++; $display("FAIL frame_last beat=%0d got %b want %b", got, last_a, (got % 4 == 3)); end
                    n_tests++; if (last_d !== 1'b1) begin n_fail++; $display("FAIL frame_last_len1 beat=%0d got %b want 1", got, last_d); end
                    void'(q_sent.pop_front());
                    got++;
                end
            end
            held = vld_a && !out_ready;
            hd = data_a; hl = last_a; hs = sat_a;
            acc = in_valid && rdy_a;
            if (acc) begin
                q_sent.push_back(in_q);
                sent++;
            end
        end
        n_tests++; if (got != 10) begin n_fail++; $display("FAIL stream_count got %0d want 10 (cycles %0d)", got, cyc); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL no_duplicate cycle=%0d out_valid got %b want 0", k, vld_a); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0]  qs [4];
        logic [32:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_q = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        n_tests++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL inflight_valid got %b want 1", vld_a); end
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b want 0", vld_a); end
        n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", rdy_a); end
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL stale_beat cycle=%0d out_valid got %b want 0", k, vld_a); end
        end
        for (int j = 0; j < 4; j++) qs[j] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 8; j++) begin
            if (j >= 3 && j <= 6) begin
                e = ref_deq(qs[j-3], ZP_A, SC_A);
                n_tests++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL b2b_valid beat=%0d got %b want 1", j - 3, vld_a); end
                n_tests++; if ({sat_a, data_a} !== e) begin n_fail++; $display("FAIL b2b_data beat=%0d got %h want %h", j - 3, data_a, e[31:0]); end
                n_tests++; if (last_a !== (j == 6)) begin n_fail++; $display("FAIL post_reset_last beat=%0d got %b want %b", j - 3, last_a, (j == 6)); end
            end else begin
                n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle cycle=%0d got %b want 0", j, vld_a); end
            end
            if (j < 4) begin
                in_valid = 1'b1; in_q = qs[j];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle=%0d got %b want 1", j, rdy_a); end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_known_values();
        test_frame_stream();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
